// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: tracks operands by CDB wake-up, issues the lowest
// ready entry each cycle and registers the ALU result back toward the CDB.
module alu_rs_scheduler #(
   parameter int RS_SIZE   = 8,
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   input  logic                 in_valid,
   input  logic [3:0]           in_op,
   input  logic [31:0]          in_vj,
   input  logic [31:0]          in_vk,
   input  logic                 in_qj_valid,
   input  logic                 in_qk_valid,
   input  logic [ROB_WIDTH-1:0] in_qj,
   input  logic [ROB_WIDTH-1:0] in_qk,
   input  logic [ROB_WIDTH-1:0] in_rob,
   output logic                 full,
   input  logic                 cdb_valid,
   input  logic [ROB_WIDTH-1:0] cdb_rob,
   input  logic [31:0]          cdb_value,
   output logic                 alu_cal,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   output logic [3:0]           alu_op,
   input  logic                 alu_cal_out,
   input  logic [31:0]          alu_result,
   output logic                 out_valid,
   output logic [ROB_WIDTH-1:0] out_rob,
   output logic [31:0]          out_value
);
   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0]   busy, qj_valid, qk_valid;
   logic [3:0]           op_q [RS_SIZE];
   logic [31:0]          vj   [RS_SIZE];
   logic [31:0]          vk   [RS_SIZE];
   logic [ROB_WIDTH-1:0] qj   [RS_SIZE];
   logic [ROB_WIDTH-1:0] qk   [RS_SIZE];
   logic [ROB_WIDTH-1:0] rob  [RS_SIZE];
   logic [ROB_WIDTH-1:0] tag1;

   logic             sel_found, free_found, issue, alloc, byp_j, byp_k;
   logic [IDX_W-1:0] sel_idx, free_idx;

   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         if (!sel_found && busy[i] && !qj_valid[i] && !qk_valid[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
         if (!free_found && !busy[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign full  = &busy;
   assign issue = rdy_in && !clear && sel_found;
   assign alloc = rdy_in && !clear && in_valid && free_found;
   assign byp_j = cdb_valid && in_qj_valid && (in_qj == cdb_rob);
   assign byp_k = cdb_valid && in_qk_valid && (in_qk == cdb_rob);

   always_comb begin
      alu_cal = issue;
      alu_a   = '0;
      alu_b   = '0;
      alu_op  = '0;
      if (issue) begin
         alu_a  = vj[sel_idx];
         alu_b  = vk[sel_idx];
         alu_op = op_q[sel_idx];
      end
   end

   // Wake-up only touches busy entries and allocation only a free one, so the
   // three updates below never target the same field in one cycle.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy     <= '0;
         qj_valid <= '0;
         qk_valid <= '0;
         tag1     <= '0;
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            op_q[i] <= '0;
            vj[i]   <= '0;
            vk[i]   <= '0;
            qj[i]   <= '0;
            qk[i]   <= '0;
            rob[i]  <= '0;
         end
      end else if (rdy_in) begin
         if (clear) begin
            busy <= '0;
            tag1 <= '0;
         end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
               if (busy[i] && cdb_valid) begin
                  if (qj_valid[i] && qj[i] == cdb_rob) begin
                     vj[i]       <= cdb_value;
                     qj_valid[i] <= 1'b0;
                  end
                  if (qk_valid[i] && qk[i] == cdb_rob) begin
                     vk[i]       <= cdb_value;
                     qk_valid[i] <= 1'b0;
                  end
               end
            end
            if (issue) begin
               busy[sel_idx] <= 1'b0;
               tag1          <= rob[sel_idx];
            end
            if (alloc) begin
               busy[free_idx]     <= 1'b1;
               op_q[free_idx]     <= in_op;
               vj[free_idx]       <= byp_j ? cdb_value : in_vj;
               vk[free_idx]       <= byp_k ? cdb_value : in_vk;
               qj_valid[free_idx] <= in_qj_valid && !byp_j;
               qk_valid[free_idx] <= in_qk_valid && !byp_k;
               qj[free_idx]       <= in_qj;
               qk[free_idx]       <= in_qk;
               rob[free_idx]      <= in_rob;
            end
         end
      end
   end

   // A returning ALU result is captured even while stalled; flush wins over it.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         out_valid <= 1'b0;
         out_rob   <= '0;
         out_value <= '0;
      end else if (rdy_in && clear) begin
         out_valid <= 1'b0;
      end else if (alu_cal_out) begin
         out_valid <= 1'b1;
         out_rob   <= tag1;
         out_value <= alu_result;
      end else if (rdy_in) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: doc/alu_rs_scheduler.md
# alu_rs_scheduler

Reservation station and issue scheduler for the single integer ALU in the out-of-order core. It accepts decoded ALU micro-ops tagged with a ROB index, tracks their operands by wake-up on the common data bus (CDB), and dispatches one ready op per cycle to the ALU. It returns each registered ALU result, paired with its ROB tag, to the CDB arbiter. It sits between the dispatch stage and the ALU, and honours the global `rdy_in` stall and `clear` flush.

## Interface
- `RS_SIZE`, 8: number of station entries (power of two, 2..16).
- `ROB_WIDTH`, 4: width of ROB tags.

- `clk_in` in 1: clock, rising edge.
- `rst_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: global enable; 0 freezes the block, except as noted under Operation.
- `clear` in 1: synchronous flush on misprediction; acts only when `rdy_in`=1.
- `in_valid` in 1: new op from dispatch.
- `in_op` in 4: ALU opcode (ADD=0 … SLTU=9).
- `in_vj`, `in_vk` in 32: operand values.
- `in_qj_valid`, `in_qk_valid` in 1: operand pending.
- `in_qj`, `in_qk` in ROB_WIDTH: producer tags.
- `in_rob` in ROB_WIDTH: destination ROB tag.
- `full` out 1: all entries valid; dispatch must not assert `in_valid`.
- `cdb_valid` in 1, `cdb_rob` in ROB_WIDTH, `cdb_value` in 32: CDB broadcast, including this block's own result.
- `alu_cal` out 1, `alu_a` out 32, `alu_b` out 32, `alu_op` out 4: ALU request (combinational).
- `alu_cal_out` in 1, `alu_result` in 32: ALU result, one cycle after the request.
- `out_valid` out 1, `out_rob` out ROB_WIDTH, `out_value` out 32: registered result to the CDB arbiter.

## Operation
- **Entry fields:** busy, op, vj, vk, qj_valid, qj, qk_valid, qk, rob.
- **Ready rule:** an entry is ready when busy=1, qj_valid=0 and qk_valid=0.
- **Allocation:** when `in_valid`=1 and `full`=0, the lowest-index non-busy entry loads the input fields at the clock edge.
- **Same-cycle bypass:** if `cdb_valid`=1 and `cdb_rob` equals `in_qj` (with `in_qj_valid`=1), the entry stores vj=`cdb_value` and qj_valid=0. The same applies independently to k.
- **Wake-up:** each busy entry whose pending qj or qk equals `cdb_rob` while `cdb_valid`=1 captures `cdb_value` and clears that q bit. Both operands may wake on the same broadcast.
- **Select:**
  - The lowest-index ready entry drives `alu_cal`=1, `alu_a`=vj, `alu_b`=vk, `alu_op`=op.
  - Its busy bit clears at the edge, and its rob is loaded into `tag1`.
  - With no ready entry: `alu_cal`=0, and `alu_a`/`alu_b`/`alu_op` are 0.
- **No same-cycle issue:** an entry written or woken at edge E becomes eligible only in the cycle after E.
- **Result stage:** when `alu_cal_out`=1, load `out_valid`=1, `out_rob`=`tag1`, `out_value`=`alu_result`. Otherwise, if `rdy_in`=1, clear `out_valid`.
- **`full`:** combinational AND of all busy bits. The freeing of an entry in a given cycle does not deassert `full` until the next cycle.
- **`in_valid` while full:** the op is ignored; this is a protocol violation that the bench flags.
- **`rdy_in`=0:**
  - No allocation, wake-up, select or flush; `alu_cal`=0.
  - The result stage still loads on `alu_cal_out`=1, so an in-flight result is not lost. Otherwise `out_*` hold.
- **`clear` with `rdy_in`=1:**
  - All busy bits clear, `tag1` is invalidated, and `out_valid` is 0 after the edge.
  - `alu_cal` is 0 during the `clear` cycle.
  - Any `in_valid` or CDB input in that cycle is ignored.
- **Reset:** all busy bits are 0, `out_valid`=0, `out_rob`=0, `out_value`=0, `tag1`=0. With no entries busy, `full`=0 and `alu_cal`=0.

## Timing
- **Op written at edge E0:**
  - If ready, it can assert `alu_cal` in cycle E0..E1.
  - The ALU registers at E1, so `alu_cal_out` is high in E1..E2.
  - `out_valid` is high in E2..E3.
  - Minimum latency from `in_valid` to `out_valid` is 2 cycles after the write edge.
- **Throughput:** one dispatch per cycle; results stream back-to-back.
- **Dependent ops:** a consumer woken by `out_*` (via the CDB) at edge E issues in the cycle following E. Back-to-back dependent ops therefore issue 3 cycles apart.
- **Outstanding ops:** at most one op is in flight between `tag1` and the result stage per cycle; `tag1` is overwritten on every issue.

## Test plan
- **Reset:** reset asserted mid-stream with 3 busy entries → next cycle `full`=0, `alu_cal`=0, `out_valid`=0; a later dispatch behaves normally.
- **Independent ADD:** ADD 5+7 with rob=3 and no pending operands → `alu_cal` with a=5, b=7; `out_valid` 2 cycles after write with `out_rob`=3, `out_value`=12.
- **Wake-up and ordering:** entry0 SUB with qj=2 pending, entry1 XOR ready.
  - XOR issues first.
  - CDB rob=2, value=10 → SUB issues the next cycle with a=10.
- **Same-cycle bypass:** `in_qk`=5 pending while the CDB broadcasts rob=5, value=9 in the write cycle → entry stores vk=9 and issues the following cycle.
- **Full:** fill 8 entries, all pending on tag 7 → `full`=1 and `in_valid` is ignored. CDB tag 7 → lowest index issues first, one per cycle, and `full` drops the cycle after the first issue.
- **Stall and flush:**
  - `rdy_in`=0 the cycle after an issue → the result is still captured, and `out_valid` stays high until `rdy_in`=1 for one edge.
  - `clear` with 4 busy entries → all dropped; nothing issues afterwards.
